counter_ctrl: RTL

Sequencer for the 3-bit mod-8 register counter. It clears the counter, then issues one-cycle `clk_en` strobes at a programmable prescaled rate. It runs either one-shot, stopping after a target count with a `done` pulse, or continuously with a `wrap` pulse at each 7→0 rollover. It sits between control logic and the counter instance, and is the only driver of the counter's `clk_en` and clear inputs.

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/counter_ctrl_tick_prescaler.sv | 28 ++
 rtl/counter_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the mod-8 counter sequencer: state encoding,
// default widths and run-mode constants.
package counter_ctrl_pkg;

  localparam int CNT_W_DEF = 3;
  localparam int PRE_W_DEF = 4;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_PAUSED);
  endfunction

endpackage

// File: rtl/counter_ctrl_tick_prescaler.sv
// Prescale counter: loads zero on clr, holds when inc is low, and wraps to
// zero after the cycle in which it matches limit.
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [PRE_W-1:0] limit,
  output logic             term
);

  logic [PRE_W-1:0] cnt;

  assign term = (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (inc && term)) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for an external 3-bit counter: clears it, then strobes clk_en at
// the prescaled rate in one-shot (done pulse) or continuous (wrap pulse) mode.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] target,
  input  logic [PRE_W-1:0] prescale,
  input  logic             pause,
  input  logic             stop,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             clk_en,
  output logic             ctr_clr_n,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [2:0]       dbg_state
);

  // start is a level request accepted only in IDLE; busy rising is the
  // acknowledgement, and there is no back-pressure on any other input.
  state_t           state, next_state;
  logic             mode_l;
  logic [CNT_W-1:0] target_l;
  logic [PRE_W-1:0] prescale_l;
  logic             pre_term;
  logic             terminal;
  logic [CNT_W-1:0] last_cnt;

  tick_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != ST_RUN) && (state != ST_PAUSED)),
    .inc   (state == ST_RUN),
    .limit (prescale_l),
    .term  (pre_term)
  );

  // target 0 wraps to a terminal value of 7, giving a full 8-tick run
  assign last_cnt = target_l - CNT_W'(1);
  assign terminal = (mode_l == MODE_ONESHOT) && clk_en && (cnt_q == last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start && !stop) next_state = ST_CLEAR;
      ST_CLEAR:  next_state = stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (stop)          next_state = ST_IDLE;
        else if (terminal) next_state = ST_DONE;
        else if (pause)    next_state = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (stop)        next_state = ST_IDLE;
        else if (!pause) next_state = ST_RUN;
      end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_en    = (state == ST_RUN) && pre_term;
    busy      = is_busy(state);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_l     <= MODE_ONESHOT;
      target_l   <= '0;
      prescale_l <= '0;
      ctr_clr_n  <= 1'b1;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start && !stop) begin
        mode_l     <= mode;
        target_l   <= target;
        prescale_l <= prescale;
      end
      ctr_clr_n <= (next_state != ST_CLEAR);
      done      <= (next_state == ST_DONE);
      wrap      <= clk_en && (cnt_q == {CNT_W{1'b1}});
    end
  end

endmodule
